// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants for the fetch stage and the decode blocks downstream.
package fetch_unit_pkg;

    localparam int          ISA_XLEN      = 32;
    localparam logic [31:0] ISA_NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] ISA_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect input, instruction-memory request/response, decode handshake.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = ISA_XLEN
);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    // Environment side: execute, instruction memory and decode.
    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous circular-buffer FIFO of fetched {instr, pc} entries with flush.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];

    // Pointer and occupancy update; flush behaves like a reset of the bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count/empty guard every read of a stale entry.
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC and credit tracking, stale-response dropping, queue to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = ISA_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ISA_RESET_PC),
    parameter int              QDEPTH   = 4
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    localparam int              AW        = $clog2(QDEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW:0]     CREDITS   = (CW + 1)'(QDEPTH);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW:0]     in_use;
    logic            q_full;
    logic            q_empty;
    logic            req_fire;
    logic            resp_keep;
    logic            resp_drop;
    logic            id_fire;
    entry_t          head;

    assign redirect_target = bus.redirect_pc & WORD_MASK;

    // Queued entries plus in-flight requests may never exceed the queue size,
    // so every response that is kept is guaranteed a slot.
    assign in_use = {1'b0, q_count} + {1'b0, outstanding};

    // Requests are held off during reset and in a redirect cycle.
    assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (in_use < CREDITS);
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Responses belonging to requests issued before a redirect are discarded;
    // so is a response landing in the redirect cycle itself.
    assign resp_drop = bus.imem_resp_valid && (drop_cnt != '0);
    assign resp_keep = bus.imem_resp_valid && !bus.redirect_valid && (drop_cnt == '0);

    assign id_fire = bus.id_valid && bus.id_ready;

    fetch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (resp_keep),
        .push_data ({bus.imem_resp_data, resp_pc}),
        .pop       (id_fire),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign bus.id_valid = !q_empty;
    assign bus.id_instr = q_empty ? XLEN'(ISA_NOP_INSTR) : head.instr;
    assign bus.id_pc    = q_empty ? '0 : head.pc;

    // PC, response-PC, credit and drop bookkeeping; a redirect overrides normal advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
            if (bus.redirect_valid) begin
                pc       <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= outstanding - CW'(bus.imem_resp_valid);
            end else begin
                if (req_fire)  pc       <= pc + XLEN'(4);
                if (resp_keep) resp_pc  <= resp_pc + XLEN'(4);
                if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Memory must never answer a request that was not issued.
    a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_resp_valid |-> (outstanding != '0));

    // The credit rule keeps kept responses from ever overflowing the queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        resp_keep |-> (!q_full || id_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a request/response-level reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int XLEN   = 32;
    localparam int QDEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: requests in flight (with stale marks), instructions decode should see.
    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] addr; int due; }   mreq_t;

    flight_t     inflight[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_fetch;
    mreq_t       pend[$];
    int          last_due   = 0;
    int          cyc        = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    bit          model_live = 0;

    // Per-cycle snapshot for directed checks.
    bit          s_req_valid, s_fire, s_id_valid, s_pop, s_resp;
    logic [31:0] s_req_addr, s_id_pc;

    // One clock cycle: sample at the falling edge, compare, advance model and memory.
    task automatic cycle();
        bit      exp_rv;
        bit      fire;
        flight_t f;
        int      due;
        @(negedge clk);
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_id_valid  = bus.id_valid;
        s_id_pc     = bus.id_pc;
        s_resp      = bus.imem_resp_valid;
        s_fire      = s_req_valid && bus.imem_req_ready;
        s_pop       = s_id_valid && bus.id_ready && !bus.redirect_valid && rst_n;

        exp_rv = rst_n && !bus.redirect_valid && ((exp_q.size() + inflight.size()) < QDEPTH);
        if (model_live) begin
            check("req_valid", s_req_valid, exp_rv);
            if (exp_rv) check("req_addr", s_req_addr, next_fetch);
            check("id_valid", s_id_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("id_pc", s_id_pc, exp_q[0]);
                check("id_instr", bus.id_instr, mem_word(exp_q[0]));
            end else begin
                check("id_pc_empty", s_id_pc, 0);
                check("id_instr_nop", bus.id_instr, 32'h0000_0013);
            end
        end

        if (!rst_n) begin
            inflight.delete();
            exp_q.delete();
            pend.delete();
            next_fetch = 32'h0;
            last_due   = cyc;
            model_live = 1;
        end else begin
            fire = exp_rv && bus.imem_req_ready;
            if (exp_q.size() != 0 && bus.id_ready && !bus.redirect_valid)
                void'(exp_q.pop_front());
            if (bus.imem_resp_valid && inflight.size() != 0) begin
                f = inflight.pop_front();
                if (!f.stale && !bus.redirect_valid) exp_q.push_back(f.addr);
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                foreach (inflight[i]) inflight[i].stale = 1;
                next_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
            end
            if (fire) begin
                inflight.push_back('{addr: next_fetch, stale: 0});
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: next_fetch, due: due});
                next_fetch = next_fetch + 32'd4;
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bit          found_fire, found_pop;
        logic [31:0] first_fire, first_pop;
        logic [31:0] pops[$];
        int          fires;

        rst_n               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.id_ready        = 1'b1;

        // Reset, then streaming with 1-cycle memory and decode always ready.
        rst_n = 1'b0;
        cycle();
        check("rst_req_valid", s_req_valid, 0);
        cycle();
        check("rst_id_valid", s_id_valid, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 0) check("A_first_req_addr", s_req_addr, 32'h0);
            if (k == 1) check("A_latency_not_yet", s_id_valid, 0);
            if (k >= 2) begin
                check("A_stream_valid", s_id_valid, 1);
                check("A_stream_pc", s_id_pc, 32'((k - 2) * 4));
            end
        end

        // Decode stalled: exactly QDEPTH requests, then drain in order and resume.
        do_reset(1);
        bus.id_ready = 1'b0;
        fires = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            fires += int'(s_fire);
        end
        check("B_fire_count", fires, 4);
        check("B_req_stalled", s_req_valid, 0);
        bus.id_ready = 1'b1;
        found_fire = 0;
        first_fire = '0;
        pops.delete();
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (s_pop) pops.push_back(s_id_pc);
            if (s_fire && !found_fire) begin
                found_fire = 1;
                first_fire = s_req_addr;
            end
        end
        check("B_pop_count_ok", pops.size() >= 4, 1);
        for (int i = 0; i < 4 && i < pops.size(); i++) check("B_drain_pc", pops[i], 32'(i * 4));
        check("B_resume_addr", first_fire, 32'h10);

        // 3-cycle memory, redirect to 0x100 with three requests in flight.
        do_reset(1);
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 3; k++) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        cycle();
        check("C_redirect_no_req", s_req_valid, 0);
        check("C_resp_in_redirect", s_resp, 1);
        check("C_queue_empty", s_id_valid, 0);
        bus.redirect_valid = 1'b0;
        cycle();
        check("C_next_req_fire", s_fire, 1);
        check("C_next_req_addr", s_req_addr, 32'h100);
        found_pop = 0;
        first_pop = '0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_pop && !found_pop) begin
                found_pop = 1;
                first_pop = s_id_pc;
            end
        end
        check("C_pop_found", found_pop, 1);
        check("C_first_id_pc", first_pop, 32'h100);
        lat_min = 1;
        lat_max = 1;

        // Redirect coinciding with a response and a pop; low address bits ignored.
        do_reset(1);
        for (int k = 0; k < 5; k++) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        cycle();
        check("D_resp_same_cycle", s_resp, 1);
        check("D_pop_attempt", s_id_valid, 1);
        bus.redirect_valid = 1'b0;
        cycle();
        check("D_flushed", s_id_valid, 0);
        check("D_req_addr", s_req_addr, 32'h200);
        cycle();
        cycle();
        check("D_first_valid", s_id_valid, 1);
        check("D_first_pc", s_id_pc, 32'h200);

        // Reset for one cycle with a full queue.
        do_reset(1);
        bus.id_ready = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        check("E_queue_full_valid", s_id_valid, 1);
        rst_n = 1'b0;
        cycle();
        check("E_req_in_reset", s_req_valid, 0);
        rst_n = 1'b1;
        cycle();
        check("E_id_valid_after", s_id_valid, 0);
        check("E_req_valid_after", s_req_valid, 1);
        check("E_req_addr_after", s_req_addr, 32'h0);

        // PC wraps from the top of the address space.
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        check("F_top_addr", s_req_addr, 32'hFFFF_FFFC);
        cycle();
        check("F_wrap_fire", s_fire, 1);
        check("F_wrap_addr", s_req_addr, 32'h0);
        for (int k = 0; k < 6; k++) cycle();

        // Randomized traffic against the model.
        lat_min = 1;
        lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            rst_n              = !($urandom_range(0, 999) < 3);
            bus.redirect_valid = ($urandom_range(0, 99) < 6);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : 32'($urandom);
            bus.imem_req_ready = ($urandom_range(0, 99) < 75);
            bus.id_ready       = ($urandom_range(0, 99) < 70);
            cycle();
        end

        // Quiet drain.
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        for (int k = 0; k < 20; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of decode (imm_gen and the control decoder consume its output).
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions with their PC in a small queue.
- Presents them to decode over a valid/ready handshake.
- A redirect from execute (branch/jump) flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, datapath/address width (matches `XLEN).
RESET_PC, 32'h0000_0000, first fetch address after reset.
QDEPTH, 4, instruction queue entries; power of two, ≥2; also the cap on queued + outstanding requests.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
redirect_valid  in  1  execute requests PC redirect this cycle
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  response data valid (in order, latency ≥1 cycle)
imem_resp_data  in  XLEN  fetched instruction
id_valid  out  1  queue head valid to decode
id_ready  in  1  decode accepts head
id_instr  out  XLEN  head instruction
id_pc  out  XLEN  PC of head instruction

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc ← RESET_PC, resp_pc ← RESET_PC.
  - Queue empty; outstanding = 0; drop_cnt = 0.
  - Outputs are registered-state driven: id_valid=0, imem_req_valid=0.
  - Requests resume the cycle after rst_n is sampled high.
  - Reset mid-operation drops everything in flight; memory responses arriving after reset are not expected (memory is reset on the same signal).
- Empty queue: id_valid=0, id_instr=`NOP_INSTR (32'h0000_0013), id_pc=0.
- Request issue:
  - imem_req_valid = !redirect_valid && (count + outstanding < QDEPTH).
  - imem_req_addr = pc.
  - Fire = valid & ready. On fire: pc += 4 (wraps modulo 2^XLEN), outstanding++.
  - Valid is not sticky: memory must only act on same-cycle valid&ready.
- Response:
  - If drop_cnt > 0: discard and decrement drop_cnt.
  - Otherwise push {resp_data, resp_pc} into the queue and increment resp_pc by 4.
  - Either way, decrement outstanding.
  - The credit rule guarantees the push never overflows. A response arriving when outstanding=0 is a protocol error; simulation assertion.
- Decode handshake:
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle are allowed, at any occupancy including full.
  - Queue is a circular buffer with log2(QDEPTH)-bit pointers wrapping naturally, plus a count of width log2(QDEPTH)+1.
- Redirect (highest priority):
  - Queue flushed; a pop in the same cycle is ignored.
  - pc ← {redirect_pc[XLEN-1:2],2'b0}; resp_pc ← same.
  - drop_cnt ← outstanding − resp_valid. The same-cycle response is itself discarded.
  - outstanding ← outstanding − resp_valid.
  - No request is issued in the redirect cycle. The first request to the target goes out the next cycle.
  - Back-to-back redirects: each applies the above; the latest target wins.
- Latency: for a 1-cycle memory, request at cycle N → response N+1 → id_valid at N+2 (queue output registered from storage, no bypass).
- Throughput: one instruction per cycle sustained when memory and decode are always ready.
- Outstanding and drop_cnt widths: log2(QDEPTH)+1; neither exceeds QDEPTH.

Decomposition:
- Shared include (isa.v): `XLEN, `NOP_INSTR (32'h0000_0013), `RESET_PC default.
- One sub-module, fetch_queue:
  - Parameterised sync FIFO of {instr, pc}.
  - flush, push, pop, full, empty, count.
  - Same clk/rst_n convention.
- Credit, drop and PC logic stay in fetch_unit.

Test Plan:
- Reset, then memory always ready with 1-cycle latency returning addr-dependent data, id_ready=1 → id_pc sequence 0x0,0x4,0x8… from cycle 2 after reset release; one instruction per cycle; id_instr matches data.
- id_ready=0 for 10 cycles → exactly QDEPTH=4 requests issued, then imem_req_valid=0. On id_ready=1, PCs 0x0–0xC drain in order, then fetching resumes at 0x10.
- 3-cycle memory latency, redirect_pc=0x100 while 3 requests are outstanding → 3 responses discarded, queue empty, next request addr 0x100, first id_pc=0x100.
- Redirect coinciding with a response and an id pop, redirect_pc=0x203 → response dropped, queue flushed, next imem_req_addr=0x200.
- rst_n low for 1 cycle mid-stream with a full queue → id_valid=0 next cycle, imem_req_valid=0 during reset, next request addr=RESET_PC.
- pc=0xFFFF_FFFC fetch → following request address wraps to 0x0000_0000.
